// File: rtl/risc_run_ctrl.sv
// rtl/risc_run_ctrl.sv - program load, core reset sequencing and run supervision
// for the RISC core family: load over valid/ready, run until halt or cycle budget.
module risc_run_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF,
  parameter int CNT_WIDTH    = 16,
  parameter int MAX_CYCLES   = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  prog_valid,
  output logic                  prog_ready,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_rst,
  input  logic [DATA_WIDTH-1:0] core_instr,
  output logic                  done,
  output logic [1:0]            status,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] ST_NONE     = 2'b00;
  localparam logic [1:0] ST_HALTED   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_OVERFLOW = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(MAX_CYCLES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0]            status_q, status_d;

  logic                    beat;
  logic                    halt;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    unused_instr_bits;

  assign opcode            = core_instr[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign unused_instr_bits = ^core_instr[DATA_WIDTH-OPCODE_WIDTH-1:0];
  assign halt              = (opcode == HALT_OPCODE);
  assign beat              = (state_q == S_LOAD) && prog_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      status_q <= ST_NONE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    status_d = status_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_LOAD;
          addr_d   = '0;
          cnt_d    = '0;
          status_d = ST_NONE;
        end
      end

      S_LOAD: begin
        if (beat) begin
          // The address saturates at the top of memory; overflow ends the load.
          if (addr_q != ADDR_MAX) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
          if (prog_last) begin
            state_d = S_RUN;
          end else if (addr_q == ADDR_MAX) begin
            state_d  = S_DONE;
            status_d = ST_OVERFLOW;
          end
        end
      end

      S_RUN: begin
        // Halt is checked first so it wins over a coincident timeout.
        if (halt) begin
          state_d  = S_DONE;
          status_d = ST_HALTED;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    prog_ready  = 1'b0;
    core_rst    = 1'b1;
    done        = 1'b0;
    imem_we     = beat;
    imem_addr   = addr_q;
    imem_wdata  = prog_data;
    status      = status_q;
    cycle_count = cnt_q;

    case (state_q)
      S_LOAD:  prog_ready = 1'b1;
      S_RUN:   core_rst   = 1'b0;
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

endmodule
